// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of the 128 KiB data RAM: one access per grant, byte-merged stores, registered responses.
// Optional: define ARB_ROUND_ROBIN_EN to alternate grants on ties instead of fixed priority to port 0.
module ram_arbiter #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_BYTES   = ADDRESS_WIDTH'(32'h0002_0000)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr,
  input  logic [31:0]              m0_wdata,
  input  logic [3:0]               m0_be,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [31:0]              m0_rdata,
  output logic                     m0_err,
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr,
  input  logic [31:0]              m1_wdata,
  input  logic [3:0]               m1_be,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [31:0]              m1_rdata,
  output logic                     m1_err,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                   state;
  logic                     we_l;
  logic                     err_l;
  logic                     port_l;
  logic                     last_grant;
  logic [ADDRESS_WIDTH-3:0] addr_l;
  logic [31:0]              wdata_l;
  logic [3:0]               be_l;

  logic                     pick_m1;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [31:0]              sel_wdata;
  logic [3:0]               sel_be;
  logic                     sel_err;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_m1 = m1_req & (~m0_req | ~last_grant);
`else
    // last_grant only matters when nobody requests, where the choice is discarded anyway
    pick_m1 = ~m0_req & (m1_req | last_grant);
`endif
    sel_we    = pick_m1 ? m1_we    : m0_we;
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
    sel_be    = pick_m1 ? m1_be    : m0_be;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= MEM_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_l       <= 1'b0;
      err_l      <= 1'b0;
      port_l     <= 1'b0;
      last_grant <= 1'b1;
      addr_l     <= '0;
      wdata_l    <= '0;
      be_l       <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state      <= ACCESS;
            we_l       <= sel_we;
            addr_l     <= sel_addr[ADDRESS_WIDTH-1:2];
            wdata_l    <= sel_wdata;
            be_l       <= sel_be;
            err_l      <= sel_err;
            port_l     <= pick_m1;
            last_grant <= pick_m1;
            m0_gnt     <= ~pick_m1;
            m1_gnt     <= pick_m1;
          end
        end
        ACCESS: begin
          state  <= IDLE;
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          // Writes also return the pre-write word seen during the access
          if (port_l) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= err_l ? 32'h0 : ram_rdata;
            m1_err    <= err_l;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= err_l ? 32'h0 : ram_rdata;
            m0_err    <= err_l;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == ACCESS) begin
      ram_we   = we_l & ~err_l & (be_l != 4'b0000);
      ram_addr = {addr_l, 2'b00};
      // Read-modify-write in one cycle via the combinational RAM read port
      for (int k = 0; k < 4; k++) begin
        ram_wdata[8*k +: 8] = be_l[k] ? wdata_l[8*k +: 8] : ram_rdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 128 KiB combinational-read RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic [31:0] mem [0:32767];
  int          checks = 0;
  int          passes = 0;
  int          we_count = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr[16:2]];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[16:2]] <= ram_wdata;
      we_count++;
    end
  end

  // One complete transaction on one port; lat is the number of cycles from req to grant
  task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err, output bit rv_ok,
                         output int lat, output logic saw_we, output logic [31:0] seen_wdata);
    @(posedge clk); #1;
    if (port) begin
      m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end else begin
      m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end
    lat = 0;
    @(negedge clk);
    while (((port ? m1_gnt : m0_gnt) !== 1'b1) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    saw_we     = ram_we;
    seen_wdata = ram_wdata;
    m0_req = 0;
    m1_req = 0;
    @(posedge clk); #1;
    rv_ok = port ? (m1_rvalid === 1'b1 && m0_rvalid === 1'b0)
                 : (m0_rvalid === 1'b1 && m1_rvalid === 1'b0);
    rdata = port ? m1_rdata : m0_rdata;
    err   = port ? m1_err : m0_err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; bit ok; int lat; logic swe; logic [31:0] swd;
    do_reset();
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_we} !== 7'b0)
      $display("[TB] FAIL reset_ctrl: got %b, want 0000000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_we});
    else passes++;
    checks++;
    if ({m0_rdata, m1_rdata, ram_addr, ram_wdata} !== 128'h0)
      $display("[TB] FAIL reset_data: got %h, want 0", {m0_rdata, m1_rdata, ram_addr, ram_wdata});
    else passes++;
    // Harmless read to leave a known state before the functional tests
    run_txn(0, 0, 32'h0, 32'h0, 4'h0, rd, er, ok, lat, swe, swd);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; bit ok; int lat; logic swe; logic [31:0] swd;
    run_txn(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, rd, er, ok, lat, swe, swd);
    checks++; if (lat !== 1) $display("[TB] FAIL wr_gnt_latency: got %0d, want 1", lat); else passes++;
    checks++; if (swe !== 1'b1) $display("[TB] FAIL wr_ram_we: got %b, want 1", swe); else passes++;
    checks++; if (swd !== 32'hDEADBEEF) $display("[TB] FAIL wr_ram_wdata: got %h, want deadbeef", swd); else passes++;
    checks++; if (!ok || er !== 1'b0) $display("[TB] FAIL wr_resp: rvalid_ok %0d err %b, want 1 0", ok, er); else passes++;
    checks++; if (mem[64] !== 32'hDEADBEEF) $display("[TB] FAIL wr_mem: got %h, want deadbeef", mem[64]); else passes++;
    run_txn(0, 0, 32'h100, 32'h0, 4'h0, rd, er, ok, lat, swe, swd);
    checks++; if (swe !== 1'b0) $display("[TB] FAIL rd_ram_we: got %b, want 0", swe); else passes++;
    checks++; if (!ok || rd !== 32'hDEADBEEF || er !== 1'b0)
      $display("[TB] FAIL rd_resp: ok %0d rdata %h err %b, want 1 deadbeef 0", ok, rd, er); else passes++;
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd; logic er; bit ok; int lat; logic swe; logic [31:0] swd;
    mem[128] = 32'h11223344;
    run_txn(1, 1, 32'h200, 32'h0000AA00, 4'b0010, rd, er, ok, lat, swe, swd);
    checks++; if (swd !== 32'h1122AA44) $display("[TB] FAIL merge_wdata: got %h, want 1122aa44", swd); else passes++;
    checks++; if (!ok || rd !== 32'h11223344 || er !== 1'b0)
      $display("[TB] FAIL merge_wr_resp: ok %0d rdata %h err %b, want 1 11223344 0", ok, rd, er); else passes++;
    run_txn(1, 0, 32'h200, 32'h0, 4'h0, rd, er, ok, lat, swe, swd);
    checks++; if (!ok || rd !== 32'h1122AA44)
      $display("[TB] FAIL merge_readback: ok %0d rdata %h, want 1 1122aa44", ok, rd); else passes++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; bit ok; int lat; logic swe; logic [31:0] swd; int wc0;
    mem[0] = 32'hCAFEF00D;
    wc0 = we_count;
    run_txn(0, 0, 32'h102, 32'h0, 4'h0, rd, er, ok, lat, swe, swd);
    checks++; if (!ok || er !== 1'b1 || rd !== 32'h0)
      $display("[TB] FAIL misalign_rd: ok %0d err %b rdata %h, want 1 1 0", ok, er, rd); else passes++;
    run_txn(1, 1, 32'h20000, 32'hFFFFFFFF, 4'hF, rd, er, ok, lat, swe, swd);
    checks++; if (!ok || er !== 1'b1 || rd !== 32'h0 || swe !== 1'b0)
      $display("[TB] FAIL range_wr: ok %0d err %b rdata %h we %b, want 1 1 0 0", ok, er, rd, swe); else passes++;
    run_txn(0, 1, 32'h100, 32'h12345678, 4'h0, rd, er, ok, lat, swe, swd);
    checks++; if (!ok || er !== 1'b0 || swe !== 1'b0)
      $display("[TB] FAIL be0_wr: ok %0d err %b we %b, want 1 0 0", ok, er, swe); else passes++;
    checks++; if (we_count !== wc0) $display("[TB] FAIL err_we_count: got %0d, want %0d", we_count, wc0); else passes++;
    checks++; if (mem[0] !== 32'hCAFEF00D || mem[64] !== 32'hDEADBEEF)
      $display("[TB] FAIL err_mem: got %h %h, want cafef00d deadbeef", mem[0], mem[64]); else passes++;
    mem[32767] = 32'hA5A5A5A5;
    run_txn(1, 0, 32'h1FFFC, 32'h0, 4'h0, rd, er, ok, lat, swe, swd);
    checks++; if (!ok || er !== 1'b0 || rd !== 32'hA5A5A5A5)
      $display("[TB] FAIL last_word: ok %0d err %b rdata %h, want 1 0 a5a5a5a5", ok, er, rd); else passes++;
  endtask

  task automatic test_contention();
    int g0 = 0, g1 = 0, cyc = 0, last_cyc = -2, bad_order = 0, bad_gap = 0, both_rv = 0;
    int exp0, exp1;
    bit rr;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1; exp0 = 4; exp1 = 4;
`else
    rr = 0; exp0 = 8; exp1 = 0;
`endif
    do_reset();
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    while ((g0 + g1) < 8 && cyc < 40) begin
      @(negedge clk);
      if (m0_rvalid && m1_rvalid) both_rv++;
      if (m0_gnt || m1_gnt) begin
        if (m1_gnt !== (rr ? ((g0 + g1) % 2 == 1) : 1'b0)) bad_order++;
        if (m0_gnt === m1_gnt) bad_order++;
        if (last_cyc >= 0 && cyc - last_cyc != 2) bad_gap++;
        last_cyc = cyc;
        if (m0_gnt) g0++; else g1++;
      end
      cyc++;
    end
    m0_req = 0;
    m1_req = 0;
    repeat (2) @(posedge clk);
    checks++; if (g0 != exp0 || g1 != exp1)
      $display("[TB] FAIL tie_counts: got %0d/%0d, want %0d/%0d", g0, g1, exp0, exp1); else passes++;
    checks++; if (bad_order != 0) $display("[TB] FAIL tie_order: got %0d bad grants, want 0", bad_order); else passes++;
    checks++; if (bad_gap != 0 || both_rv != 0)
      $display("[TB] FAIL tie_spacing: got gaps %0d both_rvalid %0d, want 0 0", bad_gap, both_rv); else passes++;
  endtask

  task automatic test_back_to_back();
    logic g_prev = 0;
    int gnts = 0, bad = 0;
    @(posedge clk); #1;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m1_gnt === ((i % 2) == 1)) ; else bad++;
      if (m1_rvalid !== g_prev) bad++;
      if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) bad++;
      if (m1_rvalid === 1'b1 && m1_rdata !== 32'h1122AA44) bad++;
      if (m1_gnt === 1'b1) gnts++;
      g_prev = m1_gnt;
    end
    m1_req = 0;
    repeat (2) @(posedge clk);
    checks++; if (gnts != 6) $display("[TB] FAIL held_gnt_count: got %0d, want 6", gnts); else passes++;
    checks++; if (bad != 0) $display("[TB] FAIL held_pattern: got %0d bad samples, want 0", bad); else passes++;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; bit ok; int lat; logic swe; logic [31:0] swd;
    mem[192] = 32'h0;
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h300; m0_wdata = 32'h12345678; m0_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1 || ram_we !== 1'b1)
      $display("[TB] FAIL rst_pre: gnt %b we %b, want 1 1", m0_gnt, ram_we); else passes++;
    #1 rst_n = 0;
    #1;
    checks++; if (m0_gnt !== 1'b0 || ram_we !== 1'b0)
      $display("[TB] FAIL rst_async: gnt %b we %b, want 0 0", m0_gnt, ram_we); else passes++;
    m0_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0)
      $display("[TB] FAIL rst_outputs: rv %b%b we %b addr %h, want 00 0 0", m0_rvalid, m1_rvalid, ram_we, ram_addr); else passes++;
    checks++; if (mem[192] !== 32'h0) $display("[TB] FAIL rst_mem: got %h, want 0", mem[192]); else passes++;
    run_txn(0, 0, 32'h100, 32'h0, 4'h0, rd, er, ok, lat, swe, swd);
    checks++; if (lat != 1 || !ok || rd !== 32'hDEADBEEF)
      $display("[TB] FAIL rst_recover: lat %0d ok %0d rdata %h, want 1 1 deadbeef", lat, ok, rd); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_errors();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
